if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage feeding the decode/rename stage. Generates sequential PCs, issues one request per cycle to a fixed-latency instruction memory, buffers returned words with their PCs in a small fetch queue, and presents them to decode through a valid/ready handshake. A branch mispredict from execute flushes the queue, drops the in-flight response and restarts fetch at the redirect PC.

## Interface
- PC_W, 16, PC and instruction-memory address width (byte address)
- INST_W, 32, instruction width
- FQ_DEPTH, 4, fetch-queue entries (power of two, ≥2)
- RESET_PC, 16'h0000, first fetch address after reset
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- im_req_valid  out  1  fetch request this cycle
- im_req_addr  out  PC_W  request byte address
- im_resp_valid  in  1  response valid; always exactly 1 cycle after an accepted request
- im_resp_inst  in  INST_W  returned instruction word
- mispredict  in  1  redirect request from execute
- redirect_pc  in  PC_W  target PC, sampled when mispredict=1
- IF_out_pc  out  PC_W  PC of queue head
- IF_out_inst  out  INST_W  instruction at queue head
- IF_valid  out  1  queue head valid for decode
- DC_ready  in  1  decode accepts head this cycle

## Operation
- Registers: pc_q, req_pc_q (PC of in-flight request), pend_q (request in flight), fetch queue (head, tail, count).
- Request rule: im_req_valid = !mispredict && (count + pend_q) < FQ_DEPTH; im_req_addr = pc_q. Memory always accepts; on request pc_q <= pc_q + 4 (wraps modulo 2^PC_W), req_pc_q <= pc_q, pend_q <= 1; otherwise pend_q <= 0.
- Response: when pend_q && im_resp_valid, push {req_pc_q, im_resp_inst}. im_resp_valid without pend_q is ignored. Credit rule guarantees push never overflows.
- Dequeue: pop when IF_valid && DC_ready. IF_valid = (count != 0) && !mispredict. IF_out_pc/IF_out_inst show the head entry, 0 when queue empty or mispredict=1.
- Push and pop in same cycle: count unchanged, both pointers advance; legal at full and empty+push.
- Mispredict (cycle t): no request, no pop, no push; at edge: pc_q <= redirect_pc, count/head/tail <= 0, pend_q <= 0 (response arriving in t is dropped). Flush wins over all simultaneous events.
- Back-to-back mispredicts: each reloads pc_q; last one wins.

## Timing
- Reset values: pc_q=RESET_PC, pend_q=0, count=head=tail=0; outputs im_req_valid=0 during rst, then 1 in first cycle after deassertion with im_req_addr=RESET_PC; IF_valid=0, IF_out_pc=0, IF_out_inst=0.
- Reset mid-operation clears all state immediately (asynchronous); any returned word is discarded.
- Request in cycle t → response in t+1 → IF_valid in t+2 (fetch-to-decode latency 2).
- Steady state with DC_ready=1: one instruction per cycle.
- DC_ready=0: queue fills to FQ_DEPTH, requests stop once count+pend_q=FQ_DEPTH; resume the cycle after a pop frees a credit.
- Mispredict in t: first request to redirect_pc in t+1, IF_valid for it in t+3.

## Structure
- Shared package: PC_W/INST_W constants, fetch-queue entry struct {pc, inst}, reset-PC constant.
- One sub-module: fetch_fifo (parameterised depth/width sync FIFO with push, pop, flush, count; flush priority over push/pop).

## Test plan
- Reset release, DC_ready=1, memory returns addr-based words → IF_out_pc 0,4,8,12… one per cycle from cycle 2, instructions matching.
- DC_ready=0 for 10 cycles → exactly 4 entries queued, im_req_valid low after 4 requests; DC_ready=1 drains 0,4,8,12 in order, fetch resumes at 16.
- mispredict=1 with redirect_pc=16'h0100 while queue holds 3 entries and one pending → IF_valid=0 that cycle, next request addr 0x0100, next IF_out_pc 0x0100 in t+3, no stale PCs.
- Mispredict coinciding with full queue, pop and response → queue empty, response dropped.
- pc_q=16'hFFFC → next request addr 16'h0000.
- Assert rst mid-stream with 2 entries queued → IF_valid=0 immediately, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared constants and the fetch-queue entry type for the instruction-fetch stage.
// No logic of its own.
// Imported by if_stage and its bench.
package if_stage_pkg;

  localparam int PC_W           = 16;
  localparam int INST_W         = 32;
  localparam int DEF_FQ_DEPTH   = 4;
  localparam logic [PC_W-1:0] DEF_RESET_PC = 16'h0000;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst} entries; flush beats push/pop.
// Latency: a pushed word is visible at head the cycle after the push edge.
// No internal backpressure: the caller's credit scheme keeps push off when full.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 48
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  // Pointer and occupancy update; flush empties the queue regardless of push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[tail] <= push_data;
  end

  assign head_data = mem[head];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: sequential PC generation, fixed 1-cycle imem, fetch queue to decode.
// Latency: request in t, response in t+1, IF_valid in t+2; redirect restarts fetch next cycle.
// Requests are credit-limited so queued plus in-flight words never exceed FQ_DEPTH.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int              FQ_DEPTH = DEF_FQ_DEPTH,
  parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  output logic              im_req_valid,
  output logic [PC_W-1:0]   im_req_addr,
  input  logic              im_resp_valid,
  input  logic [INST_W-1:0] im_resp_inst,
  input  logic              mispredict,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [PC_W-1:0]   IF_out_pc,
  output logic [INST_W-1:0] IF_out_inst,
  output logic              IF_valid,
  input  logic              DC_ready
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] req_pc_q;
  logic            pend_q;
  logic [CW-1:0]   count;
  logic [CW:0]     credits_used;
  logic            push;
  logic            pop;
  fq_entry_t       push_e;
  fq_entry_t       head_e;

  // The in-flight request already owns a queue slot, so it counts against credit.
  assign credits_used = {1'b0, count} + (CW+1)'(pend_q);
  assign im_req_valid = !rst && !mispredict && (credits_used < (CW+1)'(FQ_DEPTH));
  assign im_req_addr  = pc_q;

  assign push        = pend_q && im_resp_valid && !mispredict;
  assign push_e.pc   = req_pc_q;
  assign push_e.inst = im_resp_inst;

  assign IF_valid    = (count != '0) && !mispredict;
  assign pop         = IF_valid && DC_ready;
  assign IF_out_pc   = IF_valid ? head_e.pc   : '0;
  assign IF_out_inst = IF_valid ? head_e.inst : '0;

  // PC sequencing and in-flight tracking; a redirect reloads the PC and forgets the pending word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      pend_q   <= 1'b0;
    end else if (mispredict) begin
      pc_q   <= redirect_pc;
      pend_q <= 1'b0;
    end else if (im_req_valid) begin
      pc_q     <= pc_q + PC_W'(4);
      req_pc_q <= pc_q;
      pend_q   <= 1'b1;
    end else begin
      pend_q <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH (FQ_DEPTH),
    .W     ($bits(fq_entry_t))
  ) u_fq (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_e),
    .pop       (pop),
    .flush     (mispredict),
    .head_data (head_e),
    .count     (count)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with an imem model and a scoreboard of outstanding fetches.
// Every cycle compares request and decode-side outputs against the scoreboard.
// Decode readiness and redirects are driven per step.
module tb_if_stage;
  import if_stage_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              im_req_valid;
  logic [PC_W-1:0]   im_req_addr;
  logic              im_resp_valid;
  logic [INST_W-1:0] im_resp_inst;
  logic              mispredict;
  logic [PC_W-1:0]   redirect_pc;
  logic [PC_W-1:0]   IF_out_pc;
  logic [INST_W-1:0] IF_out_inst;
  logic              IF_valid;
  logic              DC_ready;

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .im_req_valid  (im_req_valid),
    .im_req_addr   (im_req_addr),
    .im_resp_valid (im_resp_valid),
    .im_resp_inst  (im_resp_inst),
    .mispredict    (mispredict),
    .redirect_pc   (redirect_pc),
    .IF_out_pc     (IF_out_pc),
    .IF_out_inst   (IF_out_inst),
    .IF_valid      (IF_valid),
    .DC_ready      (DC_ready)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard: every accepted request in order; the newest is still in flight when mpend=1.
  logic [47:0]     sb [$];
  logic            mpend = 1'b0;
  logic [PC_W-1:0] mpc = DEF_RESET_PC;
  logic            last_ifv = 1'b0;
  int              nreq = 0;
  int              lat;

  function automatic logic [INST_W-1:0] mem_word(input logic [PC_W-1:0] a);
    return {a ^ 16'hA5A5, a};
  endfunction

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s: wait bound expired", tag);
  endtask

  task automatic step();
    logic            exp_req, exp_v, req_seen, pop_now, mp, r;
    logic [PC_W-1:0] addr_seen, rp;
    logic [47:0]     e;
    @(negedge clk);
    exp_req = !rst && !mispredict && (sb.size() < DEF_FQ_DEPTH);
    exp_v   = !rst && !mispredict && ((sb.size() - int'(mpend)) > 0);
    check("req_valid", 48'(im_req_valid), 48'(exp_req));
    if (exp_req) check("req_addr", 48'(im_req_addr), 48'(mpc));
    check("if_valid", 48'(IF_valid), 48'(exp_v));
    if (exp_v) begin
      e = sb[0];
      check("out_pc", 48'(IF_out_pc), 48'(e[47:32]));
      check("out_inst", 48'(IF_out_inst), 48'(e[31:0]));
    end else begin
      check("out_zero", {IF_out_pc, IF_out_inst}, 48'h0);
    end
    if (im_req_valid) nreq++;
    last_ifv  = IF_valid;
    req_seen  = im_req_valid;
    addr_seen = im_req_addr;
    pop_now   = exp_v && DC_ready;
    mp        = mispredict;
    rp        = redirect_pc;
    r         = rst;
    @(posedge clk);
    #1;
    im_resp_valid = req_seen;
    im_resp_inst  = mem_word(addr_seen);
    if (r) begin
      sb.delete(); mpend = 1'b0; mpc = DEF_RESET_PC;
    end else if (mp) begin
      sb.delete(); mpend = 1'b0; mpc = rp;
    end else begin
      if (pop_now) void'(sb.pop_front());
      if (exp_req) begin
        sb.push_back({mpc, mem_word(mpc)});
        mpc   = mpc + 16'd4;
        mpend = 1'b1;
      end else begin
        mpend = 1'b0;
      end
    end
  endtask

  task automatic wait_landed(input int n, input string tag);
    int k = 0;
    while (!(((sb.size() - int'(mpend)) == n) && mpend) && k < 20) begin
      step();
      k++;
    end
    if (k >= 20) timeout(tag);
  endtask

  task automatic measure_latency(input string tag);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!last_ifv && lat < 10);
    check(tag, 48'(lat), 48'd3);
  endtask

  initial begin
    rst = 1'b1; im_resp_valid = 1'b0; im_resp_inst = '0;
    mispredict = 1'b0; redirect_pc = '0; DC_ready = 1'b1;
    #1;
    check("reset_req_valid", 48'(im_req_valid), 48'd0);
    check("reset_if_valid", 48'(IF_valid), 48'd0);
    repeat (3) step();
    rst = 1'b0;

    // Streaming from reset: first word reaches decode two cycles after the first request.
    measure_latency("startup_latency");
    repeat (10) step();

    // Backpressure from an empty queue: exactly FQ_DEPTH requests, then drain in order.
    mispredict = 1'b1; redirect_pc = 16'h0000; DC_ready = 1'b0;
    step();
    mispredict = 1'b0;
    nreq = 0;
    repeat (10) step();
    check("bp_request_count", 48'(nreq), 48'd4);
    DC_ready = 1'b1;
    repeat (10) step();

    // Redirect with three queued entries and one in flight.
    DC_ready = 1'b0;
    wait_landed(3, "wait_three_queued");
    mispredict = 1'b1; redirect_pc = 16'h0100;
    step();
    mispredict = 1'b0; DC_ready = 1'b1;
    measure_latency("redirect_latency");
    repeat (4) step();

    // Redirect coinciding with a pop and an arriving response.
    DC_ready = 1'b0;
    wait_landed(3, "wait_full_credit");
    DC_ready = 1'b1; mispredict = 1'b1; redirect_pc = 16'h0200;
    step();
    mispredict = 1'b0;
    repeat (6) step();

    // Back-to-back redirects, last wins, then PC wrap past 16'hFFFC.
    mispredict = 1'b1; redirect_pc = 16'h0300;
    step();
    redirect_pc = 16'hFFF8;
    step();
    mispredict = 1'b0;
    repeat (8) step();

    // Asynchronous reset with two entries queued.
    DC_ready = 1'b0;
    wait_landed(2, "wait_two_queued");
    rst = 1'b1;
    #1;
    check("async_rst_if_valid", 48'(IF_valid), 48'd0);
    check("async_rst_req_valid", 48'(im_req_valid), 48'd0);
    check("async_rst_out_pc", 48'(IF_out_pc), 48'd0);
    sb.delete(); mpend = 1'b0; mpc = DEF_RESET_PC;
    repeat (2) step();
    rst = 1'b0; DC_ready = 1'b1;
    measure_latency("post_reset_latency");
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
